// File: rtl/traffic_light_controller_if.sv
// Sensor/light bundle for the two-street traffic light controller.
// The controller takes the slave side; the environment drives sensors as master.
interface traffic_light_controller_if;
  logic       Ta;
  logic       Tb;
  logic [1:0] La;
  logic [1:0] Lb;

  modport master (output Ta, Tb, input La, Lb);
  modport slave  (input Ta, Tb, output La, Lb);
endinterface

// File: rtl/traffic_light_controller.sv
// Moore traffic light controller for streets A and B. Green hands over only after
// the holding street's sensor drops, through a single-cycle yellow phase.
module traffic_light_controller (
  input  logic                       clk,
  input  logic                       reset_n,  // active-high despite the name
  traffic_light_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  state_e     state_q, state_d;
  logic [1:0] la_q, lb_q;
  logic [1:0] la_d, lb_d;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = bus.Ta ? S0 : S1;
      S1:      state_d = S2;
      S2:      state_d = bus.Tb ? S2 : S3;
      S3:      state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Lights are decoded from the next state so the registered outputs track state_q exactly.
  always_comb begin
    la_d = RED;
    lb_d = RED;
    case (state_d)
      S0:      begin la_d = GREEN;  lb_d = RED;    end
      S1:      begin la_d = YELLOW; lb_d = RED;    end
      S2:      begin la_d = RED;    lb_d = GREEN;  end
      S3:      begin la_d = RED;    lb_d = YELLOW; end
      default: begin la_d = RED;    lb_d = RED;    end
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= S0;
      la_q    <= GREEN;
      lb_q    <= RED;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end

  assign bus.La = la_q;
  assign bus.Lb = lb_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed plus randomized bench for traffic_light_controller against a
// street/phase model (which street holds green, and whether it is in yellow).
module tb_traffic_light_controller;

  logic clk;
  logic reset_n;
  traffic_light_controller_if bus();

  traffic_light_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: street holding right-of-way, and whether it is showing yellow.
  bit green_b = 1'b0;
  bit yellow  = 1'b0;

  function automatic logic [1:0] light(input bit is_b);
    if (green_b != is_b) return 2'b10;
    return yellow ? 2'b01 : 2'b00;
  endfunction

  task automatic model_reset();
    green_b = 1'b0;
    yellow  = 1'b0;
  endtask

  task automatic model_step(input bit ta, input bit tb);
    bit sensor;
    if (yellow) begin
      yellow  = 1'b0;
      green_b = ~green_b;
    end else begin
      sensor = green_b ? tb : ta;
      if (!sensor) yellow = 1'b1;
    end
  endtask

  task automatic check(input string tag);
    logic [1:0] ea, eb;
    ea = light(1'b0);
    eb = light(1'b1);
    tests++;
    assert (bus.La === ea) else begin
      fails++;
      $error("FAIL %s La got=%b exp=%b", tag, bus.La, ea);
    end
    tests++;
    assert (bus.Lb === eb) else begin
      fails++;
      $error("FAIL %s Lb got=%b exp=%b", tag, bus.Lb, eb);
    end
    tests++;
    assert (bus.La === 2'b10 || bus.Lb === 2'b10) else begin
      fails++;
      $error("FAIL %s safety La=%b Lb=%b exp one red", tag, bus.La, bus.Lb);
    end
  endtask

  // Drive sensors (called just after a negedge), clock once, check after the edge.
  task automatic step(input bit ta, input bit tb, input string tag);
    bus.Ta = ta;
    bus.Tb = tb;
    @(posedge clk);
    model_step(ta, tb);
    #1;
    check(tag);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.Ta  = 1'b0;
    bus.Tb  = 1'b0;

    // Asynchronous reset before any clock edge
    #1 reset_n = 1'b1;
    model_reset();
    #1 check("reset_async");
    @(posedge clk); #1 check("reset_held");
    @(negedge clk);
    reset_n = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "hold_A");
    step(1'b0, 1'b1, "handover_AB_yellow");
    step(1'b0, 1'b1, "handover_AB_green");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, "hold_B_both");
    step(1'b1, 1'b0, "handover_BA_yellow");
    step(1'b1, 1'b0, "handover_BA_green");
    step(1'b0, 1'b0, "leave_A");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "free_run");

    // Reach S2 then reset between edges
    while (!(green_b && !yellow)) step(1'b0, 1'b1, "to_S2");
    @(posedge clk); #2;
    reset_n = 1'b1;
    model_reset();
    #1 check("reset_mid_S2");
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "after_reset_hold_A");

    // Randomized sensors with occasional asynchronous reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 reset_n = 1'b1;
        model_reset();
        #1 check("rand_reset");
        @(negedge clk);
        reset_n = 1'b0;
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Moore-type traffic light controller for an intersection of two streets, A and B. Each street has a traffic sensor; each street has a 2-bit light output. Green passes to the other street only after the current street's sensor reports no traffic and a one-cycle yellow phase. The block is a self-contained leaf: a state register, next-state logic and output decode, all driven by a single clock.

## Interface
- Parameters: none. The light encoding and state encoding are fixed constants inside the block.
- clk  input  1  system clock; all state changes occur on the rising edge.
- reset_n  input  1  asynchronous reset, active-high.
  - Asserted when 1. The name is kept for codebase consistency.
  - Forces the state to S0 immediately, without waiting for a clock edge.
- Ta  input  1  traffic sensor, street A; 1 = traffic present.
- Tb  input  1  traffic sensor, street B; 1 = traffic present.
- La  output  2  light for street A: 2'b00 green, 2'b01 yellow, 2'b10 red.
- Lb  output  2  light for street B, same encoding as La.
- Encoding 2'b11 is never driven on La or Lb.

## Operation
- Four states, stored in a 2-bit state register:
  - S0 = 2'b00
  - S1 = 2'b01
  - S2 = 2'b10
  - S3 = 2'b11
- Outputs per state (Moore; outputs depend only on the state):
  - S0: La green (00), Lb red (10).
  - S1: La yellow (01), Lb red (10).
  - S2: La red (10), Lb green (00).
  - S3: La red (10), Lb yellow (01).
- Transitions, evaluated at each rising clk edge:
  - S0: Ta=1 -> stay in S0; Ta=0 -> S1.
  - S1: -> S2 unconditionally.
  - S2: Tb=1 -> stay in S2; Tb=0 -> S3.
  - S3: -> S0 unconditionally.
- Sensor relevance:
  - Tb is ignored in S0, S1 and S3.
  - Ta is ignored in S1, S2 and S3.
- Both sensors asserted together: the current green street keeps green for as long as its own sensor stays 1. There is no fairness timer.
- Safety invariant: La and Lb are never both non-red. At least one of the two outputs is 2'b10 in every state.
- Illegal or unknown state value: the next state is S0 (default branch of the next-state logic).
- Output decode has a default of La=Lb=red (10).

## Timing
- Reset value of the outputs: La=2'b00 and Lb=2'b10 (state S0).
  - Applied asynchronously while reset_n=1.
  - Held for as long as reset_n=1.
- Reset release: the first state evaluation happens at the first rising clk edge after reset_n falls to 0.
- Sensor sampling: Ta and Tb are sampled at the rising clk edge. No input registering or synchronizer is used; the sensors are synchronous to clk.
- Latency: an output change appears after the same rising edge that changes the state. There is no extra pipeline stage.
- Yellow duration: exactly 1 clk cycle (S1, S3).
- Green duration:
  - Minimum 1 cycle.
  - Otherwise extends while the street's sensor remains 1.
- Minimum full cycle with both sensors at 0: S0->S1->S2->S3->S0, which is 4 clocks.
- Reset mid-operation: from any state, asserting reset_n returns the block to S0 (La=00, Lb=10) without waiting for clk.

## Test plan
- Reset check: reset_n=1 for 1 cycle with Ta=Tb=0 -> La=00, Lb=10 during reset, with no clk edge required.
- Hold green A: release reset, Ta=1 for 4 cycles -> state remains S0 (La=00, Lb=10) every cycle.
- Handover A->B: Ta falls to 0, Tb=1 ->
  - next edge: La=01, Lb=10;
  - following edge: La=10, Lb=00;
  - state held in S2 while Tb=1 (6 cycles).
- Handover B->A: Tb falls to 0 ->
  - next edge: La=10, Lb=01;
  - following edge: back to La=00, Lb=10.
- Free-run: Ta=Tb=0 for 8 cycles -> outputs repeat the sequence (00,10),(01,10),(10,00),(10,01) with period 4. The pair (non-red, non-red) never appears.
- Async reset mid-cycle: assert reset_n between clock edges while in S2 -> La=00, Lb=10 immediately. After release with Ta=1, the state stays in S0.
